// File: rtl/microwave_ctrl_p.sv
// Microwave controller: BCD mm:ss keypad entry, countdown with door interlock,
// pause/resume, and power-level duty cycling of the magnetron.
module microwave_ctrl_p #(
    parameter int TICKS_PER_SEC = 50,
    parameter int MIN_DIGITS    = 2,
    parameter int PWR_PERIOD    = 10
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic [9:0]              keypad,
    input  logic                    startn,
    input  logic                    stopn,
    input  logic                    door_closed,
    input  logic [3:0]              power,
    output logic                    mag,
    output logic                    timer_done,
    output logic [1:0]              state,
    output logic [6:0]              sec_ones_segs,
    output logic [6:0]              sec_tens_segs,
    output logic [7*MIN_DIGITS-1:0] min_segs
);
    localparam int NDIG = 2 + MIN_DIGITS;
    localparam int TW   = 4 * NDIG;
    localparam int PW   = $clog2(TICKS_PER_SEC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COOK   = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_q, state_n;
    logic [TW-1:0]   time_q, time_n, time_dec;
    logic [PW-1:0]   presc_q, presc_n;
    logic [3:0]      win_q, win_n;
    logic [3:0]      pwr_q, pwr_n;
    logic            full_q, full_n;
    logic [9:0]      kp_q, kp_prev_q;
    logic            start_q, start_prev_q, stop_q, stop_prev_q;
    logic            mag_q, done_q, mag_n;
    logic            key_ev, start_ev, stop_ev, tick, borrow;
    logic [3:0]      key_digit;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Keypad and buttons are captured into edge registers; an event is acted on
    // the edge after capture. Button registers reset to "pressed" (0).
    always_comb begin
        key_ev   = (kp_prev_q == '0) && (kp_q != '0) && ((kp_q & (kp_q - 10'd1)) == '0);
        key_digit = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (kp_q[i]) key_digit = 4'(i + 1);
        end
        start_ev = start_prev_q & ~start_q;
        stop_ev  = stop_prev_q & ~stop_q;
        tick     = (presc_q == PW'(TICKS_PER_SEC - 1));

        // One-second BCD decrement; seconds-tens wraps to 5, other digits to 9.
        time_dec = time_q;
        borrow   = 1'b1;
        for (int d = 0; d < NDIG; d++) begin
            if (borrow) begin
                if (time_q[4*d +: 4] == 4'd0) begin
                    time_dec[4*d +: 4] = (d == 1) ? 4'd5 : 4'd9;
                end else begin
                    time_dec[4*d +: 4] = time_q[4*d +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end

        state_n = state_q;
        time_n  = time_q;
        presc_n = presc_q;
        win_n   = win_q;
        pwr_n   = pwr_q;
        full_n  = full_q;
        case (state_q)
            IDLE: begin
                if (stop_ev) begin
                    time_n = '0;
                end else if (start_ev) begin
                    if (door_closed && (time_q != '0)) begin
                        state_n = COOK;
                        presc_n = '0;
                        win_n   = '0;
                        pwr_n   = power;
                        full_n  = (power == 4'd0) || (power > 4'(PWR_PERIOD));
                    end
                end else if (key_ev) begin
                    time_n = {time_q[TW-5:0], key_digit};
                end
            end
            COOK: begin
                if (!door_closed || stop_ev) begin
                    state_n = PAUSED;
                end else if (tick) begin
                    presc_n = '0;
                    win_n   = (win_q == 4'(PWR_PERIOD - 1)) ? 4'd0 : win_q + 4'd1;
                    time_n  = time_dec;
                    if (time_dec == '0) state_n = DONE;
                end else begin
                    presc_n = presc_q + PW'(1);
                end
            end
            PAUSED: begin
                if (stop_ev) begin
                    state_n = IDLE;
                    time_n  = '0;
                end else if (start_ev && door_closed) begin
                    state_n = COOK;
                end
            end
            DONE: begin
                if (!door_closed || stop_ev || key_ev) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        mag_n = (state_n == COOK) && door_closed && (full_n || (win_n < pwr_n));
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q       <= IDLE;
            time_q        <= '0;
            presc_q       <= '0;
            win_q         <= '0;
            pwr_q         <= '0;
            full_q        <= 1'b0;
            kp_q          <= '0;
            kp_prev_q     <= '0;
            start_q       <= 1'b0;
            start_prev_q  <= 1'b0;
            stop_q        <= 1'b0;
            stop_prev_q   <= 1'b0;
            mag_q         <= 1'b0;
            done_q        <= 1'b0;
            sec_ones_segs <= 7'h3F;
            sec_tens_segs <= 7'h3F;
            min_segs      <= {MIN_DIGITS{7'h3F}};
        end else begin
            kp_q          <= keypad;
            kp_prev_q     <= kp_q;
            start_q       <= startn;
            start_prev_q  <= start_q;
            stop_q        <= stopn;
            stop_prev_q   <= stop_q;
            state_q       <= state_n;
            time_q        <= time_n;
            presc_q       <= presc_n;
            win_q         <= win_n;
            pwr_q         <= pwr_n;
            full_q        <= full_n;
            mag_q         <= mag_n;
            done_q        <= (state_n == DONE);
            sec_ones_segs <= seg7(time_q[3:0]);
            sec_tens_segs <= seg7(time_q[7:4]);
            for (int m = 0; m < MIN_DIGITS; m++) begin
                min_segs[7*m +: 7] <= seg7(time_q[8 + 4*m +: 4]);
            end
        end
    end

    // Door gating keeps the magnetron off in the same cycle the door opens.
    assign mag        = mag_q & door_closed;
    assign timer_done = done_q;
    assign state      = state_q;

endmodule

// File: tb/tb_microwave_ctrl_p.sv
// Bench for microwave_ctrl_p: front-panel stimulus, a seconds-level reference
// model feeding an expected queue, and a monitor comparing every cycle.
module tb_microwave_ctrl_p;
    localparam int T  = 50;
    localparam int MD = 2;
    localparam int PP = 10;
    localparam int ND = 2 + MD;
    localparam int OW = 4 + 14 + 7*MD;

    logic            clk = 1'b0;
    logic            clear;
    logic [9:0]      keypad;
    logic            startn, stopn, door_closed;
    logic [3:0]      power;
    logic            mag, timer_done;
    logic [1:0]      state;
    logic [6:0]      sec_ones_segs, sec_tens_segs;
    logic [7*MD-1:0] min_segs;

    microwave_ctrl_p #(.TICKS_PER_SEC(T), .MIN_DIGITS(MD), .PWR_PERIOD(PP)) dut (
        .clk(clk), .clear(clear), .keypad(keypad), .startn(startn), .stopn(stopn),
        .door_closed(door_closed), .power(power), .mag(mag), .timer_done(timer_done),
        .state(state), .sec_ones_segs(sec_ones_segs), .sec_tens_segs(sec_tens_segs),
        .min_segs(min_segs)
    );

    always #5 clk = ~clk;

    logic [6:0]    seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [OW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            cook_cnt = 0;
    int            mag_cnt  = 0;

    // Reference model: mode, digits as plain integers, cycles cooked so far.
    int       m_state = 0;
    int       dig [ND];
    int       disp [ND];
    int       m_cook_cyc = 0;
    int       m_pwr = 0;
    bit       m_full = 1'b0;
    logic [9:0] kp_s1, kp_s2;
    bit       st_s1, st_s2, sp_s1, sp_s2;

    function automatic int get_sec();
        return dig[1]*10 + dig[0];
    endfunction

    function automatic int get_min();
        int mn = 0;
        for (int m = MD - 1; m >= 0; m--) mn = mn*10 + dig[2+m];
        return mn;
    endfunction

    task automatic zero_time();
        foreach (dig[i]) dig[i] = 0;
    endtask

    task automatic dec_time();
        int sec = get_sec();
        int mn  = get_min();
        if (sec > 0) sec--;
        else begin
            mn--;
            sec = 59;
        end
        dig[0] = sec % 10;
        dig[1] = sec / 10;
        for (int m = 0; m < MD; m++) begin
            dig[2+m] = mn % 10;
            mn = mn / 10;
        end
    endtask

    function automatic logic [OW-1:0] encode(int st, bit mg);
        logic [7*MD-1:0] ms;
        for (int m = 0; m < MD; m++) ms[7*m +: 7] = seg_tab[disp[2+m]];
        return {2'(st), 1'(st == 3), mg, ms, seg_tab[disp[1]], seg_tab[disp[0]]};
    endfunction

    task automatic model_step();
        bit key_ev, start_ev, stop_ev, mg;
        int kd;
        if (clear) begin
            m_state = 0; m_cook_cyc = 0; m_pwr = 0; m_full = 1'b0;
            zero_time();
            kp_s1 = '0; kp_s2 = '0;
            st_s1 = 0; st_s2 = 0; sp_s1 = 0; sp_s2 = 0;
            foreach (disp[i]) disp[i] = 0;
            exp_q.push_back(encode(0, 1'b0));
            return;
        end
        key_ev   = (kp_s2 == '0) && ($countones(kp_s1) == 1);
        kd = 0;
        for (int i = 0; i < 9; i++) if (kp_s1[i]) kd = i + 1;
        start_ev = st_s2 && !st_s1;
        stop_ev  = sp_s2 && !sp_s1;
        kp_s2 = kp_s1; kp_s1 = keypad;
        st_s2 = st_s1; st_s1 = startn;
        sp_s2 = sp_s1; sp_s1 = stopn;
        disp = dig;
        case (m_state)
            0: begin
                if (stop_ev) zero_time();
                else if (start_ev) begin
                    if (door_closed && (get_sec() + get_min() != 0)) begin
                        m_state = 1; m_cook_cyc = 0; m_pwr = int'(power);
                        m_full = (power == 0) || (int'(power) > PP);
                    end
                end else if (key_ev) begin
                    for (int i = ND - 1; i > 0; i--) dig[i] = dig[i-1];
                    dig[0] = kd;
                end
            end
            1: begin
                if (!door_closed || stop_ev) m_state = 2;
                else begin
                    m_cook_cyc++;
                    if (m_cook_cyc % T == 0) begin
                        dec_time();
                        if (get_sec() + get_min() == 0) m_state = 3;
                    end
                end
            end
            2: begin
                if (stop_ev) begin
                    m_state = 0;
                    zero_time();
                end else if (start_ev && door_closed) m_state = 1;
            end
            default: if (!door_closed || stop_ev || key_ev) m_state = 0;
        endcase
        mg = (m_state == 1) && door_closed && (m_full || ((m_cook_cyc / T) % PP) < m_pwr);
        exp_q.push_back(encode(m_state, mg));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        logic [OW-1:0] e, a;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {state, timer_done, mag, min_segs, sec_tens_segs, sec_ones_segs};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    if (n_fail <= 25)
                        $display("FAIL obs cyc=%0d actual st=%0d done=%0b mag=%0b segs=%h required st=%0d done=%0b mag=%0b segs=%h",
                                 cyc, a[OW-1 -: 2], a[OW-3], a[OW-4], a[OW-5:0],
                                 e[OW-1 -: 2], e[OW-3], e[OW-4], e[OW-5:0]);
                end
                if (state == 2'd1) cook_cnt++;
                if (mag) mag_cnt++;
            end
        end
    end

    task automatic check(string name, int act, int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press_key(int d);
        keypad = (d == 0) ? 10'h200 : 10'(1 << (d - 1));
        tick($urandom_range(1, 3));
        keypad = '0;
        tick(2);
    endtask

    task automatic press_start();
        startn = 1'b0;
        tick($urandom_range(1, 3));
        startn = 1'b1;
        tick(2);
    endtask

    task automatic press_stop();
        stopn = 1'b0;
        tick($urandom_range(1, 3));
        stopn = 1'b1;
        tick(2);
    endtask

    task automatic enter_num(int n, int nd);
        int p;
        for (int i = nd - 1; i >= 0; i--) begin
            p = 1;
            for (int k = 0; k < i; k++) p = p * 10;
            press_key((n / p) % 10);
        end
    endtask

    initial begin
        clear = 1'b1; keypad = '0; startn = 1'b0; stopn = 1'b0;
        door_closed = 1'b1; power = 4'd0;
        tick(3);
        clear = 1'b0;
        tick(2);
        startn = 1'b1; stopn = 1'b1;
        tick(3);

        // 1:45 counts down to 1:42 over three seconds
        enter_num(145, 3); press_start(); tick(3*T);
        press_stop(); press_stop();
        // minute borrows: 1:00 -> 0:59 and 10:00 -> 9:59
        enter_num(100, 3); press_start(); tick(T + 10);
        press_stop(); press_stop();
        enter_num(1000, 4); press_start(); tick(T + 10);
        press_stop(); press_stop();
        // 0:02 reaches DONE, a key returns to IDLE
        enter_num(2, 1); press_start(); tick(3*T);
        press_key(7); tick(3);

        // door interlock and resume; the edge leaving COOK does not count down
        enter_num(30, 2);
        cook_cnt = 0;
        press_start(); tick(5*T + 7);
        door_closed = 1'b0; tick(4);
        press_start(); tick(10);
        door_closed = 1'b1; tick(3);
        press_start(); tick(10*T + 3);
        press_stop(); tick(5);
        press_start(); tick(30*T);
        check("cook_cycles_with_pauses", cook_cnt, 30*T + 2);
        press_stop(); tick(3);

        // power 3 of 10 over 20 s; power changed after start must not matter
        power = 4'd3;
        enter_num(20, 2);
        mag_cnt = 0;
        press_start();
        power = 4'd0;
        tick(21*T);
        check("mag_cycles_power3", mag_cnt, 6*T);
        press_stop(); tick(3);

        // full power
        power = 4'd0;
        enter_num(3, 1);
        mag_cnt = 0;
        press_start(); tick(4*T);
        check("mag_cycles_full", mag_cnt, 3*T);
        press_stop(); tick(3);

        // digit shift with top discard, multi-key ignored, start with zero time
        enter_num(12345, 5);
        keypad = 10'h003; tick(3); keypad = '0; tick(3);
        press_stop();
        press_start(); tick(5);

        // randomized front-panel activity
        repeat (80) begin
            case ($urandom_range(0, 5))
                0, 1: press_key($urandom_range(0, 9));
                2: press_start();
                3: press_stop();
                4: begin door_closed = ~door_closed; tick(1); end
                default: power = 4'($urandom_range(0, 15));
            endcase
            tick($urandom_range(1, 2*T));
        end
        door_closed = 1'b1;
        tick(3);
        press_stop(); press_stop(); press_stop();

        // asynchronous clear while cooking
        power = 4'd0;
        enter_num(59, 2); press_start(); tick(T/2);
        clear = 1'b1;
        #1;
        check("clear_state", int'(state), 0);
        check("clear_mag", int'(mag), 0);
        check("clear_done", int'(timer_done), 0);
        check("clear_ones", int'(sec_ones_segs), 'h3F);
        check("clear_tens", int'(sec_tens_segs), 'h3F);
        check("clear_min0", int'(min_segs[6:0]), 'h3F);
        tick(2);
        clear = 1'b0;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/microwave_ctrl_p.md
# microwave_ctrl_p

Parametrised microwave controller: BCD keypad time entry (mm:ss), start/stop/pause/resume, door interlock, per-second countdown with configurable minute digits, and power-level duty cycling of the magnetron. It sits between the front-panel keypad and buttons and the magnetron drive and 7-segment display, replacing the fixed single-minute-digit, full-power controller.

## Interface
- TICKS_PER_SEC, 50: clk cycles per countdown second (≥2).
- MIN_DIGITS, 2: BCD minute digits (1..2); max time 9:99 or 99:99.
- PWR_PERIOD, 10: power window length in seconds (1..15).
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- keypad  in  10  one-hot digit keys; bit i (0..8) = digit i+1, bit 9 = digit 0.
- startn  in  1  start/resume button, active-low.
- stopn  in  1  stop/pause/cancel button, active-low.
- door_closed  in  1  1 = door closed.
- power  in  4  power level latched at start; 0 or >PWR_PERIOD = full power.
- mag  out  1  magnetron enable.
- timer_done  out  1  high while in DONE.
- state  out  2  IDLE=0, COOK=1, PAUSED=2, DONE=3.
- sec_ones_segs  out  7  seconds-ones digit, {g,f,e,d,c,b,a}, active-high.
- sec_tens_segs  out  7  seconds-tens digit.
- min_segs  out  7*MIN_DIGITS  minute digits, least significant in [6:0].

## Operation
- Time register: 2+MIN_DIGITS BCD digits, all 0 at reset.
- Key event: keypad goes from all-zero to exactly one bit set (sampled). Multi-bit values ignored; holding a key yields one event.
- Button press: registered 1→0 transition of startn/stopn; edge registers reset to 0 (pressed), so a button held through reset yields no event.
- IDLE: key event shifts digit in at seconds-ones, all digits shift left one place, top digit discarded. Seconds-tens accepts 0–9 (e.g. 1:90 valid).
  - start with time ≠0 and door_closed → COOK; latch power; prescaler and power-window counter cleared.
  - start with time = 0 or door open → ignored.
  - stop → time cleared to 0.
- COOK: prescaler counts 0..TICKS_PER_SEC-1; on terminal count, time decrements by one second.
  - Decrement: ones 0→9 with borrow; tens 0→5 with borrow from minutes; minutes BCD borrow across MIN_DIGITS.
  - Time reaching 0 → DONE on the same edge.
  - stop or door_closed=0 → PAUSED; prescaler and window counter held. Keys ignored.
- PAUSED: start with door_closed → COOK (resume, same power); stop → IDLE with time cleared; keys ignored.
- DONE: timer_done=1, mag=0, time 0. Any key event, stop, or door_closed=0 → IDLE. start ignored.
- Power: window counter counts seconds 0..PWR_PERIOD-1 during COOK, wrapping. mag = (state==COOK) && door_closed && (window < P), P = latched power (full power → mag always on in COOK).
- Priority in one cycle: door open > stop > start > key.
- Segment codes 0–9: 3F,06,5B,4F,66,6D,7D,07,7F,6F.

## Timing
- Reset (async): state IDLE, mag 0, timer_done 0, all digits 0 (segments 0x3F), prescaler 0, window 0.
- Key/button to state or time change: 2 clk edges (edge register, then update).
- Segment outputs registered from time; update on the edge after time changes.
- mag registered; deasserts no later than 1 edge after door_closed falls (combinational gating with door_closed is permitted).
- Seconds period in COOK: exactly TICKS_PER_SEC cycles; first decrement TICKS_PER_SEC cycles after COOK entry.
- Resume preserves prescaler: total cook time across pauses exact to the cycle.
- clear mid-cook: immediate IDLE, mag 0, time lost.

## Test plan
- Reset, keys 1,4,5, release startn then press → display 1:45, COOK, mag=1; after 3×TICKS_PER_SEC cycles shows 1:42.
- Entry 1:00 → after one second shows 0:59; entry 10:00 (MIN_DIGITS=2) → 9:59; entry 0:02 → DONE after 2 s, timer_done=1, mag=0; key press → IDLE.
- Door opened at 0:30 → PAUSED, mag=0 within 1 edge; start with door open ignored; door closed + start → resumes, total COOK cycles = entered seconds × TICKS_PER_SEC.
- power=3, PWR_PERIOD=10, 20 s cook → mag high during seconds 0–2 and 10–12 of cook only; power=0 → mag high throughout.
- Keys 1..5 typed → 2:345 digits shift, top discarded → 23:45; two keypad bits simultaneously → no change; start with time 0 → stays IDLE.
- stop in PAUSED → IDLE, display 0:00; clear asserted mid-COOK → all outputs reset values asynchronously.
